// File: rtl/mio_bus_responder_if.sv
// CPU-side memory/IO bus. The CPU (master) raises CPU_MIO with mem_w, addr
// and wdata; the responder (slave) answers with a one-cycle MIO_ready pulse
// carrying rdata.
interface mio_bus_responder_if;
   logic        CPU_MIO;
   logic        mem_w;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        MIO_ready;

   // Handshake: a request is taken only when the responder is idle and
   // CPU_MIO=1 at a rising edge; mem_w/addr/wdata are captured on that same
   // edge and may change afterwards. Completion is exactly one cycle of
   // MIO_ready=1 with rdata valid in that cycle. No back-pressure signal is
   // returned: a CPU that holds CPU_MIO high is accepted again once the
   // responder has returned to idle.
   modport master (output CPU_MIO, mem_w, addr, wdata, input rdata, MIO_ready);
   modport slave  (input CPU_MIO, mem_w, addr, wdata, output rdata, MIO_ready);
endinterface

// File: rtl/mio_bus_responder.sv
// Memory/IO bus responder: word RAM, LED register, free-running TIMER and a
// read-only switch port behind a five-state request FSM.
module mio_bus_responder #(
   parameter int RAM_WORDS = 1024,
   parameter int RD_WAIT   = 2
) (
   input  logic                clk,
   input  logic                reset,
   mio_bus_responder_if.slave  bus,
   input  logic [15:0]         sw,
   output logic [15:0]         led,
   output logic                bus_err,
   output logic                busy,
   output logic [2:0]          dbg_state_o
);
   localparam int AW = $clog2(RAM_WORDS);
   localparam logic [2:0] CNT_LOAD = 3'(RD_WAIT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_WAIT = 3'd1,
      S_WR_DO   = 3'd2,
      S_RESP    = 3'd3,
      S_TURN    = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      T_RAM   = 3'd0,
      T_LED   = 3'd1,
      T_TIMER = 3'd2,
      T_SW    = 3'd3,
      T_ERR   = 3'd4
   } tgt_t;

   state_t          state_q;
   tgt_t            tgt_q;
   tgt_t            tgt_dec;
   logic [AW-1:0]   ram_idx_q;
   logic [31:0]     wdata_q;
   logic [2:0]      cnt_q;
   logic [31:0]     rdata_q;
   logic            ready_q;
   logic [15:0]     led_q;
   logic            err_q;
   logic [31:0]     timer_q;
   logic [31:0]     periph_rd;
   logic [31:0]     ram [RAM_WORDS];

   // Decode the live request; misaligned, unmapped and SW writes all
   // collapse to T_ERR so the rest of the FSM only sees legal targets.
   always_comb begin
      tgt_dec = T_ERR;
      if (bus.addr[1:0] == 2'b00) begin
         if (bus.addr[31:AW+2] == '0)          tgt_dec = T_RAM;
         else if (bus.addr == 32'hF000_0000)   tgt_dec = T_LED;
         else if (bus.addr == 32'hF000_0004)   tgt_dec = T_TIMER;
         else if (bus.addr == 32'hE000_0000)   tgt_dec = bus.mem_w ? T_ERR : T_SW;
      end
   end

   // Peripheral read data as seen in the accept cycle (TIMER snapshot).
   always_comb begin
      periph_rd = '0;
      case (tgt_dec)
         T_LED:   periph_rd = {16'h0000, led_q};
         T_TIMER: periph_rd = timer_q;
         T_SW:    periph_rd = {16'h0000, sw};
         default: periph_rd = '0;
      endcase
   end

   // Request FSM with registered MIO_ready/rdata and the LED/error registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         tgt_q     <= T_ERR;
         ram_idx_q <= '0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         rdata_q   <= '0;
         ready_q   <= 1'b0;
         led_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.CPU_MIO) begin
                  tgt_q     <= tgt_dec;
                  ram_idx_q <= bus.addr[AW+1:2];
                  wdata_q   <= bus.wdata;
                  if (tgt_dec == T_ERR) err_q <= 1'b1;
                  if (bus.mem_w) begin
                     state_q <= S_WR_DO;
                  end else if (tgt_dec == T_RAM) begin
                     state_q <= S_RD_WAIT;
                     cnt_q   <= CNT_LOAD;
                  end else begin
                     state_q <= S_RESP;
                     ready_q <= 1'b1;
                     rdata_q <= periph_rd;
                  end
               end
            end
            S_RD_WAIT: begin
               if (cnt_q == 3'd0) begin
                  state_q <= S_RESP;
                  ready_q <= 1'b1;
                  rdata_q <= ram[ram_idx_q];
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            S_WR_DO: begin
               if (tgt_q == T_LED) led_q <= wdata_q[15:0];
               state_q <= S_RESP;
               ready_q <= 1'b1;
               rdata_q <= '0;
            end
            S_RESP:  state_q <= S_TURN;
            S_TURN:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Free-running TIMER; a write in WR_DO replaces that cycle's increment.
   always_ff @(posedge clk) begin
      if (!reset) begin
         timer_q <= '0;
      end else if (state_q == S_WR_DO && tgt_q == T_TIMER) begin
         timer_q <= wdata_q;
      end else begin
         timer_q <= timer_q + 32'd1;
      end
   end

   // RAM write port; gated by reset so an aborted write never lands.
   always_ff @(posedge clk) begin
      if (reset && state_q == S_WR_DO && tgt_q == T_RAM) begin
         ram[ram_idx_q] <= wdata_q;
      end
   end

   assign bus.rdata     = rdata_q;
   assign bus.MIO_ready = ready_q;
   assign led           = led_q;
   assign bus_err       = err_q;
   assign busy          = (state_q != S_IDLE);
   assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_mio_bus_responder.sv
module tb_mio_bus_responder;
   logic        clk;
   logic        reset;
   logic [15:0] sw;
   logic [15:0] led;
   logic        bus_err;
   logic        busy;
   logic [2:0]  dbg_state;
   int          checks;
   int          errors;

   mio_bus_responder_if bus();

   mio_bus_responder dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .sw          (sw),
      .led         (led),
      .bus_err     (bus_err),
      .busy        (busy),
      .dbg_state_o (dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one request from a negedge, scramble the bus after acceptance and
   // watch a fixed window of ten cycles for MIO_ready pulses.
   task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd, output int pulses);
      lat    = -1;
      rd     = 32'h0;
      pulses = 0;
      bus.CPU_MIO = 1'b1;
      bus.mem_w   = w;
      bus.addr    = a;
      bus.wdata   = d;
      @(posedge clk);
      #1;
      bus.CPU_MIO = 1'b0;
      bus.mem_w   = 1'($urandom_range(0, 1));
      bus.addr    = $urandom;
      bus.wdata   = $urandom;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (bus.MIO_ready === 1'b1) begin
            pulses++;
            if (lat < 0) begin
               lat = k;
               rd  = bus.rdata;
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.CPU_MIO = 1'b0; bus.mem_w = 1'b0; bus.addr = '0; bus.wdata = '0;
      sw = 16'h0;
      repeat (3) @(negedge clk);
      checks++; if (bus.MIO_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.MIO_ready); end
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
      checks++; if (led !== 16'h0) begin errors++; $display("FAIL reset_led: got %h expected 0", led); end
      checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
   endtask

   // TIMER starts from 0 at reset release: four cycles later it reads 4.
   task automatic test_timer_after_reset();
      int lat, pulses;
      logic [31:0] rd;
      reset = 1'b1;
      repeat (4) @(negedge clk);
      do_req(1'b0, 32'hF000_0004, 32'h0, lat, rd, pulses);
      checks++; if (rd !== 32'd4) begin errors++; $display("FAIL timer_start: got %h expected 00000004", rd); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL timer_rd_lat: got %0d expected 1", lat); end
   endtask

   task automatic test_ram();
      int lat, pulses;
      logic [31:0] rd;
      do_req(1'b1, 32'h0000_0010, 32'hCAFE_BABE, lat, rd, pulses);
      checks++; if (lat !== 2) begin errors++; $display("FAIL ram_wr_lat: got %0d expected 2", lat); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ram_wr_rdata: got %h expected 0", rd); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL ram_wr_pulses: got %0d expected 1", pulses); end
      do_req(1'b0, 32'h0000_0010, 32'h0, lat, rd, pulses);
      checks++; if (lat !== 3) begin errors++; $display("FAIL ram_rd_lat: got %0d expected 3", lat); end
      checks++; if (rd !== 32'hCAFE_BABE) begin errors++; $display("FAIL ram_rd_data: got %h expected cafebabe", rd); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL ram_rd_pulses: got %0d expected 1", pulses); end
      // last word of the RAM
      do_req(1'b1, 32'h0000_0FFC, 32'h1234_5678, lat, rd, pulses);
      do_req(1'b0, 32'h0000_0FFC, 32'h0, lat, rd, pulses);
      checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL ram_top_data: got %h expected 12345678", rd); end
      checks++; if (bus.rdata !== 32'h1234_5678) begin errors++; $display("FAIL rdata_hold: got %h expected 12345678", bus.rdata); end
   endtask

   task automatic test_periph();
      int lat, pulses;
      logic [31:0] rd;
      do_req(1'b1, 32'hF000_0000, 32'h0001_A5A5, lat, rd, pulses);
      checks++; if (led !== 16'hA5A5) begin errors++; $display("FAIL led_wr: got %h expected a5a5", led); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL led_wr_lat: got %0d expected 2", lat); end
      do_req(1'b0, 32'hF000_0000, 32'h0, lat, rd, pulses);
      checks++; if (rd !== 32'h0000_A5A5) begin errors++; $display("FAIL led_rd: got %h expected 0000a5a5", rd); end
      sw = 16'h1234;
      do_req(1'b0, 32'hE000_0000, 32'h0, lat, rd, pulses);
      checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL sw_rd: got %h expected 00001234", rd); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL sw_rd_lat: got %0d expected 1", lat); end
      checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL no_err_yet: got %b expected 0", bus_err); end
   endtask

   // Load 0xFFFF_FFFE; it is visible in RESP, then FFFFFFFF, 0, 1.
   task automatic test_timer_wrap();
      int lat, pulses;
      logic [31:0] rd;
      bus.CPU_MIO = 1'b1; bus.mem_w = 1'b1; bus.addr = 32'hF000_0004; bus.wdata = 32'hFFFF_FFFE;
      @(posedge clk);
      #1;
      bus.CPU_MIO = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (bus.MIO_ready !== 1'b1) begin errors++; $display("FAIL timer_wr_ready: got %b expected 1", bus.MIO_ready); end
      repeat (3) @(negedge clk);
      do_req(1'b0, 32'hF000_0004, 32'h0, lat, rd, pulses);
      checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL timer_wrap: got %h expected 00000001", rd); end
   endtask

   task automatic test_errors();
      int lat, pulses;
      logic [31:0] rd;
      do_req(1'b0, 32'hF000_0000, 32'h0, lat, rd, pulses);   // leave rdata nonzero
      do_req(1'b0, 32'h0000_0013, 32'h0, lat, rd, pulses);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL misalign_rdata: got %h expected 0", rd); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL misalign_lat: got %0d expected 1", lat); end
      checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b expected 1", bus_err); end
      do_req(1'b1, 32'h8000_0000, 32'hDEAD_DEAD, lat, rd, pulses);
      checks++; if (pulses !== 1) begin errors++; $display("FAIL unmapped_pulses: got %0d expected 1", pulses); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_rdata: got %h expected 0", rd); end
      do_req(1'b1, 32'h0000_0012, 32'h1111_1111, lat, rd, pulses);
      do_req(1'b1, 32'hE000_0000, 32'h2222_2222, lat, rd, pulses);
      do_req(1'b1, 32'hF000_0002, 32'h0000_3333, lat, rd, pulses);
      checks++; if (led !== 16'hA5A5) begin errors++; $display("FAIL err_led_kept: got %h expected a5a5", led); end
      do_req(1'b0, 32'h0000_0010, 32'h0, lat, rd, pulses);
      checks++; if (rd !== 32'hCAFE_BABE) begin errors++; $display("FAIL err_ram_kept: got %h expected cafebabe", rd); end
      checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", bus_err); end
   endtask

   // CPU_MIO held high on SW reads: accepts at cycles 0, 3, 6.
   task automatic test_back_to_back();
      logic [8:0] rdy_mask, busy_mask;
      sw = 16'h0BEE;
      bus.CPU_MIO = 1'b1; bus.mem_w = 1'b0; bus.addr = 32'hE000_0000;
      rdy_mask = '0; busy_mask = '0;
      rdy_mask[0]  = bus.MIO_ready;
      busy_mask[0] = busy;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         rdy_mask[k]  = bus.MIO_ready;
         busy_mask[k] = busy;
      end
      bus.CPU_MIO = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (rdy_mask !== 9'b010010010) begin errors++; $display("FAIL b2b_ready: got %b expected 010010010", rdy_mask); end
      checks++; if (busy_mask !== 9'b110110110) begin errors++; $display("FAIL b2b_busy: got %b expected 110110110", busy_mask); end
      checks++; if (bus.rdata !== 32'h0000_0BEE) begin errors++; $display("FAIL b2b_rdata: got %h expected 00000bee", bus.rdata); end
   endtask

   task automatic test_reset_mid_access();
      int lat, pulses;
      logic [31:0] rd;
      int late;
      do_req(1'b1, 32'hF000_0000, 32'h0000_5A5A, lat, rd, pulses);
      do_req(1'b0, 32'hF000_0000, 32'h0, lat, rd, pulses);   // rdata = 5A5A
      // abort a RAM read in RD_WAIT
      bus.CPU_MIO = 1'b1; bus.mem_w = 1'b0; bus.addr = 32'h0000_0010;
      @(posedge clk);
      #1;
      bus.CPU_MIO = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (bus.MIO_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", bus.MIO_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL abort_rdata: got %h expected 0", bus.rdata); end
      checks++; if (led !== 16'h0) begin errors++; $display("FAIL abort_led: got %h expected 0", led); end
      checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL abort_err: got %b expected 0", bus_err); end
      reset = 1'b1;
      late = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (bus.MIO_ready === 1'b1) late++;
      end
      checks++; if (late !== 0) begin errors++; $display("FAIL abort_late_ready: got %0d expected 0", late); end
      // abort a RAM write in WR_DO
      bus.CPU_MIO = 1'b1; bus.mem_w = 1'b1; bus.addr = 32'h0000_0010; bus.wdata = 32'h0BAD_F00D;
      @(posedge clk);
      #1;
      bus.CPU_MIO = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      do_req(1'b0, 32'h0000_0010, 32'h0, lat, rd, pulses);
      checks++; if (rd !== 32'hCAFE_BABE) begin errors++; $display("FAIL abort_wr_ram: got %h expected cafebabe", rd); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_timer_after_reset();
      test_ram();
      test_periph();
      test_timer_wrap();
      test_errors();
      test_back_to_back();
      test_reset_mid_access();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
